// File: rtl/ram_bus_arbiter_if.sv
// Signal bundle between the two CPU masters, the arbiter and the ram_bus slave.
// The arbiter uses the slave modport; the CPU/ram_bus side uses the master modport.
interface ram_bus_arbiter_if;
    logic        m0_stb_i, m0_cyc_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i, m0_data_i;
    logic [2:0]  m0_addr_tag_i;
    logic        m1_stb_i, m1_cyc_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i, m1_data_i;
    logic [2:0]  m1_addr_tag_i;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] m_data_o;
    logic        m_data_tag_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [2:0]  s_addr_tag_o;
    logic        s_ack_i, s_data_tag_i;
    logic [31:0] s_data_i;

    modport slave (
        input  m0_stb_i, m0_cyc_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i, m0_addr_tag_i,
        input  m1_stb_i, m1_cyc_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i, m1_addr_tag_i,
        output m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m_data_o, m_data_tag_o,
        output s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_addr_o, s_data_o, s_addr_tag_o,
        input  s_ack_i, s_data_i, s_data_tag_i
    );

    modport master (
        output m0_stb_i, m0_cyc_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i, m0_addr_tag_i,
        output m1_stb_i, m1_cyc_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i, m1_addr_tag_i,
        input  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m_data_o, m_data_tag_o,
        input  s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_addr_o, s_data_o, s_addr_tag_o,
        output s_ack_i, s_data_i, s_data_tag_i
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master Wishbone arbiter in front of ram_bus: round-robin grant held for a whole
// cycle so lock/unlock tag sequences stay unbroken, plus an ack-timeout error response.
module ram_bus_arbiter #(
    parameter bit          INIT_PRIORITY = 1'b1,
    parameter int unsigned MAX_WAIT      = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ram_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        req0_s, req1_s;
    logic        g_cyc_s, g_stb_s, g_we_s;
    logic [3:0]  g_sel_s;
    logic [31:0] g_addr_s, g_data_s;
    logic [2:0]  g_tag_s;
    logic        timeout_s, ack0_s, ack1_s, err0_s, err1_s;

    assign req0_s = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1_s = bus.m1_cyc_i & bus.m1_stb_i;

    // Next grant: held while the owner keeps cyc, handed straight over if the other master waits.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0_s && req1_s) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (req0_s) begin
                    state_d = GNT0;
                end else if (req1_s) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (bus.m0_cyc_i) begin
                    state_d = GNT0;
                end else begin
                    last_grant_d = 1'b0;
                    state_d      = req1_s ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (bus.m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    last_grant_d = 1'b1;
                    state_d      = req0_s ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields of the granted master; nothing is forwarded while idle.
    always_comb begin
        g_cyc_s  = 1'b0;
        g_stb_s  = 1'b0;
        g_we_s   = 1'b0;
        g_sel_s  = 4'd0;
        g_addr_s = 32'd0;
        g_data_s = 32'd0;
        g_tag_s  = 3'd0;
        case (state_q)
            GNT0: begin
                g_cyc_s  = bus.m0_cyc_i;
                g_stb_s  = bus.m0_stb_i;
                g_we_s   = bus.m0_we_i;
                g_sel_s  = bus.m0_sel_i;
                g_addr_s = bus.m0_addr_i;
                g_data_s = bus.m0_data_i;
                g_tag_s  = bus.m0_addr_tag_i;
            end
            GNT1: begin
                g_cyc_s  = bus.m1_cyc_i;
                g_stb_s  = bus.m1_stb_i;
                g_we_s   = bus.m1_we_i;
                g_sel_s  = bus.m1_sel_i;
                g_addr_s = bus.m1_addr_i;
                g_data_s = bus.m1_data_i;
                g_tag_s  = bus.m1_addr_tag_i;
            end
            default: begin
                g_cyc_s = 1'b0;
            end
        endcase
    end

    assign timeout_s = (MAX_WAIT != 32'd0) && g_cyc_s && g_stb_s &&
                       ({24'd0, wait_cnt_q} == MAX_WAIT);

    // A slave ack arriving while reset is asserted is dropped rather than forwarded.
    assign ack0_s = ~rst_i & (state_q == GNT0) & bus.s_ack_i & bus.m0_stb_i;
    assign ack1_s = ~rst_i & (state_q == GNT1) & bus.s_ack_i & bus.m1_stb_i;
    assign err0_s = ~rst_i & (state_q == GNT0) & timeout_s;
    assign err1_s = ~rst_i & (state_q == GNT1) & timeout_s;

    // Wait counter: restarts on grant change, ack or timeout, saturates at 8'hFF.
    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (ack0_s || ack1_s || timeout_s) begin
            wait_cnt_d = 8'd0;
        end else if (g_cyc_s && g_stb_s && !bus.s_ack_i && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= ~INIT_PRIORITY;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.s_cyc_o      = g_cyc_s;
    assign bus.s_stb_o      = g_cyc_s & g_stb_s & ~timeout_s;
    assign bus.s_we_o       = g_cyc_s & g_we_s;
    assign bus.s_sel_o      = g_cyc_s ? g_sel_s  : 4'd0;
    assign bus.s_addr_o     = g_cyc_s ? g_addr_s : 32'd0;
    assign bus.s_data_o     = g_cyc_s ? g_data_s : 32'd0;
    assign bus.s_addr_tag_o = g_cyc_s ? g_tag_s  : 3'd0;

    assign bus.m0_ack_o     = ack0_s;
    assign bus.m1_ack_o     = ack1_s;
    assign bus.m0_err_o     = err0_s;
    assign bus.m1_err_o     = err1_s;
    assign bus.m_data_o     = bus.s_data_i;
    assign bus.m_data_tag_o = bus.s_data_tag_i & (ack0_s | ack1_s);
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter (INIT_PRIORITY=1, MAX_WAIT=4): directed scenarios plus a
// randomized two-master run checked against an owner/last-served reference model.
module tb_ram_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ram_bus_arbiter_if bus ();

    ram_bus_arbiter #(.INIT_PRIORITY(1'b1), .MAX_WAIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_sel_i = 4'd0;
        bus.m0_addr_i = 32'd0; bus.m0_data_i = 32'd0; bus.m0_addr_tag_i = 3'd0;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_sel_i = 4'd0;
        bus.m1_addr_i = 32'd0; bus.m1_data_i = 32'd0; bus.m1_addr_tag_i = 3'd0;
        bus.s_ack_i = 1'b0; bus.s_data_i = 32'd0; bus.s_data_tag_i = 1'b0;
    endtask

    task automatic drive_m(input int idx, input logic cyc, input logic stb,
                           input logic [31:0] addr, input logic [2:0] tag);
        if (idx == 0) begin
            bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_addr_i = addr;
            bus.m0_addr_tag_i = tag; bus.m0_sel_i = 4'hF; bus.m0_we_i = 1'b0;
        end else begin
            bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_addr_i = addr;
            bus.m1_addr_tag_i = tag; bus.m1_sel_i = 4'hF; bus.m1_we_i = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_stb: got %b want 0", bus.s_stb_o); end
        n_cmp++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc_o); end
        n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o});
        end
        tick();
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        drive_m(0, 1'b1, 1'b1, 32'h0000_1000, 3'b000);
        drive_m(1, 1'b1, 1'b1, 32'h0000_2000, 3'b000);
        @(negedge clk);
        n_cmp++; if (bus.s_stb_o !== 1'b0) begin n_fail++; $display("FAIL sim_latency: s_stb got %b want 0", bus.s_stb_o); end
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL sim_first_addr: got %h want 00002000", bus.s_addr_o); end
        n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin n_fail++; $display("FAIL sim_first_ack: got %b want 01", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(1, 1'b0, 1'b0, 32'd0, 3'b000);
        @(negedge clk);
        n_cmp++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL sim_release: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL sim_second_addr: got %h want 00001000", bus.s_addr_o); end
        n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL sim_second_ack: got %b want 10", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 32'd0, 3'b000);
        tick();
    endtask

    task automatic test_amo_lock();
        drive_m(1, 1'b1, 1'b1, 32'h0000_0100, 3'b101);
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.s_addr_o, bus.s_addr_tag_o} !== {32'h0000_0100, 3'b101}) begin
            n_fail++; $display("FAIL amo_lock: got %h/%b want 00000100/101", bus.s_addr_o, bus.s_addr_tag_o);
        end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(1, 1'b1, 1'b0, 32'h0000_0100, 3'b101);
        drive_m(0, 1'b1, 1'b1, 32'h0000_0A00, 3'b000);
        @(negedge clk);
        n_cmp++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b10) begin n_fail++; $display("FAIL amo_gap_hold: cyc/stb got %b want 10", {bus.s_cyc_o, bus.s_stb_o}); end
        tick();
        drive_m(1, 1'b1, 1'b1, 32'h0000_0100, 3'b100);
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.s_addr_tag_o !== 3'b100) begin n_fail++; $display("FAIL amo_unlock_tag: got %b want 100", bus.s_addr_tag_o); end
        n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin n_fail++; $display("FAIL amo_unlock_ack: got %b want 01", {bus.m0_ack_o, bus.m1_ack_o}); end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(1, 1'b0, 1'b0, 32'd0, 3'b000);
        @(negedge clk);
        n_cmp++; if (bus.s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL amo_m0_wait: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.s_stb_o, bus.s_addr_o} !== {1'b1, 32'h0000_0A00}) begin
            n_fail++; $display("FAIL amo_m0_grant: stb/addr got %b/%h want 1/00000a00", bus.s_stb_o, bus.s_addr_o);
        end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 32'd0, 3'b000);
        tick();
    endtask

    task automatic test_timeout();
        drive_m(1, 1'b1, 1'b1, 32'h0000_0300, 3'b000);
        bus.s_ack_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if ({bus.s_stb_o, bus.m1_err_o} !== 2'b10) begin
                n_fail++; $display("FAIL to_wait%0d: stb/err got %b want 10", k, {bus.s_stb_o, bus.m1_err_o});
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if ({bus.m1_err_o, bus.m0_err_o, bus.m1_ack_o} !== 3'b100) begin
            n_fail++; $display("FAIL to_err: err1/err0/ack1 got %b want 100", {bus.m1_err_o, bus.m0_err_o, bus.m1_ack_o});
        end
        n_cmp++; if ({bus.s_stb_o, bus.s_cyc_o} !== 2'b01) begin n_fail++; $display("FAIL to_stb_forced: stb/cyc got %b want 01", {bus.s_stb_o, bus.s_cyc_o}); end
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.m1_err_o, bus.m1_ack_o, bus.s_stb_o} !== 3'b011) begin
            n_fail++; $display("FAIL to_after: err1/ack1/stb got %b want 011", {bus.m1_err_o, bus.m1_ack_o, bus.s_stb_o});
        end
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(1, 1'b0, 1'b0, 32'd0, 3'b000);
        tick();
    endtask

    task automatic test_sc_fail();
        logic [31:0] rdata;
        drive_m(1, 1'b1, 1'b1, 32'h0000_0400, 3'b010);
        bus.s_ack_i = 1'b1;
        bus.s_data_tag_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.m1_ack_o, bus.m_data_tag_o} !== 2'b00) begin n_fail++; $display("FAIL sc_idle_tag: ack1/tag got %b want 00", {bus.m1_ack_o, bus.m_data_tag_o}); end
        tick();
        rdata = $urandom;
        bus.s_data_i = rdata;
        @(negedge clk);
        n_cmp++; if ({bus.m1_ack_o, bus.m0_ack_o, bus.m_data_tag_o} !== 3'b101) begin
            n_fail++; $display("FAIL sc_fail_tag: ack1/ack0/tag got %b want 101", {bus.m1_ack_o, bus.m0_ack_o, bus.m_data_tag_o});
        end
        n_cmp++; if (bus.m_data_o !== rdata) begin n_fail++; $display("FAIL sc_rdata: got %h want %h", bus.m_data_o, rdata); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_m(0, 1'b1, 1'b1, 32'h0000_0500, 3'b000);
        tick();
        @(negedge clk);
        n_cmp++; if (bus.s_stb_o !== 1'b1) begin n_fail++; $display("FAIL rmid_granted: s_stb got %b want 1", bus.s_stb_o); end
        tick();
        rst = 1'b1;
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_drop: got %b want 0", bus.m0_ack_o); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.s_stb_o, bus.s_cyc_o, bus.s_we_o, bus.s_sel_o, bus.s_addr_o, bus.s_addr_tag_o, bus.s_data_o} !== 74'd0) begin
            n_fail++; $display("FAIL rmid_idle_outputs: stb/cyc/addr got %b/%b/%h want 0/0/0", bus.s_stb_o, bus.s_cyc_o, bus.s_addr_o);
        end
        n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_idle_ack: got %b want 00", {bus.m0_ack_o, bus.m1_ack_o}); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int owner, last, prev, waited;
        int starve [2];
        bit act [2];
        bit acked [2];
        bit e_ack [2];
        logic [31:0] addr [2];
        logic [31:0] e_addr;
        bit en, ack_now, dtag;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        owner = -1; last = 0; waited = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; acked[i] = 1'b0; starve[i] = 0; addr[i] = 32'd0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acked[i]) begin
                    act[i] = 1'b0; acked[i] = 1'b0;
                end else if (!act[i] && ($urandom_range(0, 3) != 0)) begin
                    act[i] = 1'b1; addr[i] = $urandom;
                end
            end
            drive_m(0, act[0], act[0], addr[0], 3'b000);
            drive_m(1, act[1], act[1], addr[1], 3'b000);
            ack_now = ($urandom_range(0, 1) == 1) || (waited >= 2);
            dtag = ($urandom_range(0, 1) == 1);
            bus.s_ack_i = ack_now;
            bus.s_data_tag_i = dtag;
            bus.s_data_i = $urandom;
            @(negedge clk);
            en = (owner == 0 && act[0]) || (owner == 1 && act[1]);
            e_addr = (owner == 0 && act[0]) ? addr[0] : ((owner == 1 && act[1]) ? addr[1] : 32'd0);
            e_ack[0] = ack_now && (owner == 0) && act[0];
            e_ack[1] = ack_now && (owner == 1) && act[1];
            n_cmp++; if ({bus.s_cyc_o, bus.s_stb_o} !== {en, en}) begin n_fail++; $display("FAIL rnd_cyc_stb c=%0d: got %b want %b%b", c, {bus.s_cyc_o, bus.s_stb_o}, en, en); end
            n_cmp++; if (bus.s_addr_o !== e_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, bus.s_addr_o, e_addr); end
            n_cmp++; if ({bus.m0_ack_o, bus.m1_ack_o} !== {e_ack[0], e_ack[1]}) begin
                n_fail++; $display("FAIL rnd_ack c=%0d: got %b want %b%b", c, {bus.m0_ack_o, bus.m1_ack_o}, e_ack[0], e_ack[1]);
            end
            n_cmp++; if (bus.m_data_tag_o !== (dtag & (e_ack[0] | e_ack[1]))) begin n_fail++; $display("FAIL rnd_tag c=%0d: got %b", c, bus.m_data_tag_o); end
            n_cmp++; if ({bus.m0_err_o, bus.m1_err_o} !== 2'b00) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b want 00", c, {bus.m0_err_o, bus.m1_err_o}); end
            for (int i = 0; i < 2; i++) begin
                if (act[i] && owner != i) starve[i]++; else starve[i] = 0;
                n_cmp++; if (starve[i] > 8) begin n_fail++; $display("FAIL rnd_starve m%0d c=%0d: waited %0d want <=8", i, c, starve[i]); end
                if (e_ack[i]) acked[i] = 1'b1;
            end
            if (en && !ack_now) waited++; else waited = 0;
            prev = owner;
            if (owner >= 0) begin
                if (!act[owner]) begin
                    last = owner;
                    owner = act[1 - owner] ? (1 - owner) : -1;
                end
            end else if (act[0] && act[1]) begin
                owner = 1 - last;
            end else if (act[0]) begin
                owner = 0;
            end else if (act[1]) begin
                owner = 1;
            end
            if (owner != prev) waited = 0;
            tick();
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_amo_lock();
        test_timeout();
        test_sc_fail();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
